// File: rtl/sequence_scan_controller.sv
// Serial pattern scanner: takes parallel words over valid/ready, shifts them MSB-first
// through a bit-history matcher and reports per-word match count, first position and a running total.
module sequence_scan_controller #(
    parameter int               DATA_W  = 16,
    parameter int               PAT_W   = 8,
    parameter logic [PAT_W-1:0] DEF_PAT = 8'b00110011,
    parameter int               DEF_LEN = 6,
    parameter int               CNT_W   = $clog2(DATA_W + 1),
    localparam int              LEN_W   = $clog2(PAT_W + 1),
    localparam int              IDX_W   = $clog2(DATA_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              cfg_we,
    input  logic [PAT_W-1:0]  cfg_pat,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  out_count,
    output logic [IDX_W-1:0]  out_first,
    output logic              out_any,
    output logic [15:0]       stat_total
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_REPORT = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   word_q, word_d;
    logic [IDX_W-1:0]    bit_idx_q, bit_idx_d;
    logic [PAT_W-1:0]    hist_q, hist_d;
    logic [LEN_W-1:0]    seen_q, seen_d;
    logic [PAT_W-1:0]    pat_q, pat_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    first_q, first_d;
    logic                found_q, found_d;
    logic [15:0]         total_q, total_d;
    logic                in_ready_q, in_ready_d;
    logic                out_valid_q, out_valid_d;
    logic [CNT_W-1:0]    out_count_q, out_count_d;
    logic [IDX_W-1:0]    out_first_q, out_first_d;
    logic                out_any_q, out_any_d;

    logic                shift_bit_s;
    logic [PAT_W-1:0]    hist_shift_s;
    logic [LEN_W-1:0]    seen_shift_s;
    logic                match_s;
    logic                cfg_ok_s;
    logic                last_bit_s;

    // Low-order ones mask selecting the active pattern bits
    function automatic logic [PAT_W-1:0] len_mask(input logic [LEN_W-1:0] len);
        logic [PAT_W-1:0] m;
        m = '0;
        for (int i = 0; i < PAT_W; i++) begin
            m[i] = (i < int'(len));
        end
        return m;
    endfunction

    // Next-state, datapath and output computation
    always_comb begin
        state_d     = state_q;
        word_d      = word_q;
        bit_idx_d   = bit_idx_q;
        hist_d      = hist_q;
        seen_d      = seen_q;
        pat_d       = pat_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        first_d     = first_q;
        found_d     = found_q;
        total_d     = total_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_count_d = out_count_q;
        out_first_d = out_first_q;
        out_any_d   = out_any_q;

        shift_bit_s  = word_q[DATA_W-1];
        hist_shift_s = {hist_q[PAT_W-2:0], shift_bit_s};
        seen_shift_s = (seen_q >= LEN_W'(PAT_W)) ? seen_q : (seen_q + LEN_W'(1));
        match_s      = (seen_shift_s >= len_q) &&
                       (((hist_shift_s ^ pat_q) & len_mask(len_q)) == '0);
        cfg_ok_s     = cfg_we && (cfg_len != '0) && (cfg_len <= LEN_W'(PAT_W));
        last_bit_s   = (bit_idx_q == IDX_W'(DATA_W - 1));

        case (state_q)
            ST_IDLE: begin
                // A config write lands before a same-cycle word, so that word sees it
                if (cfg_ok_s) begin
                    pat_d  = cfg_pat;
                    len_d  = cfg_len;
                    seen_d = '0;
                end else begin
                    pat_d  = pat_q;
                end
                if (in_valid) begin
                    word_d     = in_data;
                    bit_idx_d  = '0;
                    cnt_d      = '0;
                    first_d    = '0;
                    found_d    = 1'b0;
                    in_ready_d = 1'b0;
                    state_d    = ST_SHIFT;
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                word_d    = {word_q[DATA_W-2:0], 1'b0};
                hist_d    = hist_shift_s;
                seen_d    = seen_shift_s;
                bit_idx_d = bit_idx_q + IDX_W'(1);
                if (match_s) begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    total_d = (total_q == 16'hFFFF) ? total_q : (total_q + 16'd1);
                    if (!found_q) begin
                        found_d = 1'b1;
                        first_d = bit_idx_q;
                    end else begin
                        found_d = found_q;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
                if (last_bit_s) begin
                    state_d     = ST_REPORT;
                    out_valid_d = 1'b1;
                    out_count_d = cnt_d;
                    out_first_d = first_d;
                    out_any_d   = (cnt_d != '0);
                end else begin
                    state_d     = ST_SHIFT;
                end
            end
            ST_REPORT: begin
                if (out_ready) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end else begin
                    state_d     = ST_REPORT;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
            end
        endcase

        // Abort wins over everything in flight but keeps the programmed pattern
        if (clear) begin
            state_d     = ST_IDLE;
            hist_d      = '0;
            seen_d      = '0;
            cnt_d       = '0;
            first_d     = '0;
            found_d     = 1'b0;
            total_d     = 16'd0;
            in_ready_d  = 1'b1;
            out_valid_d = 1'b0;
            out_count_d = '0;
            out_first_d = '0;
            out_any_d   = 1'b0;
        end else begin
            total_d     = total_d;
        end
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            word_q      <= '0;
            bit_idx_q   <= '0;
            hist_q      <= '0;
            seen_q      <= '0;
            pat_q       <= DEF_PAT;
            len_q       <= LEN_W'(DEF_LEN);
            cnt_q       <= '0;
            first_q     <= '0;
            found_q     <= 1'b0;
            total_q     <= 16'd0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_count_q <= '0;
            out_first_q <= '0;
            out_any_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            word_q      <= word_d;
            bit_idx_q   <= bit_idx_d;
            hist_q      <= hist_d;
            seen_q      <= seen_d;
            pat_q       <= pat_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            first_q     <= first_d;
            found_q     <= found_d;
            total_q     <= total_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_count_q <= out_count_d;
            out_first_q <= out_first_d;
            out_any_q   <= out_any_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_count  = out_count_q;
    assign out_first  = out_first_q;
    assign out_any    = out_any_q;
    assign stat_total = total_q;

endmodule

// File: tb/tb_sequence_scan_controller.sv
// Directed bench for sequence_scan_controller: a vector table of config+word cases
// followed by hand-written cross-boundary, backpressure, config-ignore and abort sequences.
module tb_sequence_scan_controller;

    logic        clk = 1'b0;
    logic        rst, clear, cfg_we;
    logic [7:0]  cfg_pat;
    logic [3:0]  cfg_len;
    logic        in_valid, in_ready;
    logic [15:0] in_data;
    logic        out_valid, out_ready;
    logic [4:0]  out_count;
    logic [3:0]  out_first;
    logic        out_any;
    logic [15:0] stat_total;

    int n_checks  = 0;
    int n_err     = 0;
    int exp_total = 0;

    typedef struct {
        logic        do_cfg;
        logic [7:0]  pat;
        logic [3:0]  len;
        logic [15:0] word;
        int          cnt;
        int          first;
    } vec_t;

    vec_t vecs [8];

    sequence_scan_controller dut (
        .clk(clk), .rst(rst), .clear(clear),
        .cfg_we(cfg_we), .cfg_pat(cfg_pat), .cfg_len(cfg_len),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_count(out_count), .out_first(out_first), .out_any(out_any),
        .stat_total(stat_total)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset;
        rst = 1'b1; clear = 1'b0; cfg_we = 1'b0; cfg_pat = 8'h00; cfg_len = 4'd0;
        in_valid = 1'b0; in_data = 16'h0000; out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        exp_total = 0;
    endtask

    task automatic pulse_clear;
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic write_cfg(input logic [7:0] pat, input logic [3:0] len);
        cfg_we = 1'b1; cfg_pat = pat; cfg_len = len;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic accept_word(input logic [15:0] w);
        int waitc;
        waitc = 0;
        in_valid = 1'b1;
        in_data  = w;
        while (!in_ready && waitc < 50) begin
            tick();
            waitc++;
        end
        check("accept_ready", int'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        in_data  = 16'h0000;
    endtask

    task automatic wait_result(input int start, input string name, input int ecnt, input int efirst);
        int lat;
        lat = start;
        while (!out_valid && lat < 100) begin
            tick();
            lat++;
        end
        check({name, "_latency"}, lat, 16);
        check({name, "_count"}, int'(out_count), ecnt);
        check({name, "_first"}, int'(out_first), efirst);
        check({name, "_any"}, int'(out_any), (ecnt != 0) ? 1 : 0);
        check({name, "_total"}, int'(stat_total), exp_total);
    endtask

    task automatic consume(input string name);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({name, "_valid_drop"}, int'(out_valid), 0);
        check({name, "_ready_back"}, int'(in_ready), 1);
    endtask

    task automatic run_word(input string name, input logic [15:0] w, input int ecnt, input int efirst);
        accept_word(w);
        exp_total += ecnt;
        wait_result(0, name, ecnt, efirst);
        consume(name);
    endtask

    initial begin
        int saw_valid;

        // do_cfg, pat, len, word, count, first
        vecs[0] = '{1'b0, 8'h00, 4'd0, 16'hCCCC, 3, 5};
        vecs[1] = '{1'b0, 8'h00, 4'd0, 16'h000C, 0, 0};
        vecs[2] = '{1'b0, 8'h00, 4'd0, 16'hC000, 1, 1};
        vecs[3] = '{1'b1, 8'h01, 4'd1, 16'h8001, 2, 0};
        vecs[4] = '{1'b1, 8'h00, 4'd0, 16'h0003, 2, 14};
        vecs[5] = '{1'b1, 8'h0A, 4'd4, 16'hAAAA, 7, 3};
        vecs[6] = '{1'b1, 8'hFF, 4'd8, 16'hFFFF, 9, 7};
        vecs[7] = '{1'b1, 8'h02, 4'd2, 16'h0000, 0, 0};

        do_reset();
        check("reset_in_ready", int'(in_ready), 1);
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_total", int'(stat_total), 0);
        check("reset_count", int'(out_count), 0);
        check("reset_any", int'(out_any), 0);

        for (int i = 0; i < 8; i++) begin
            if (vecs[i].do_cfg) begin
                write_cfg(vecs[i].pat, vecs[i].len);
            end
            run_word($sformatf("vec%0d", i), vecs[i].word, vecs[i].cnt, vecs[i].first);
        end

        // Match spanning a word boundary, then the same with clear in between
        do_reset();
        run_word("xb_w1", 16'h000C, 0, 0);
        run_word("xb_w2", 16'hC000, 1, 1);
        pulse_clear();
        exp_total = 0;
        check("xb_clear_total", int'(stat_total), 0);
        run_word("xbc_w1", 16'h000C, 0, 0);
        pulse_clear();
        run_word("xbc_w2", 16'hC000, 0, 0);

        // Backpressure: result held while out_ready stays low
        do_reset();
        accept_word(16'hCCCC);
        exp_total += 3;
        wait_result(0, "bp", 3, 5);
        in_valid = 1'b1;
        in_data  = 16'h0000;
        for (int k = 0; k < 10; k++) begin
            tick();
            check("bp_hold_valid", int'(out_valid), 1);
            check("bp_hold_count", int'(out_count), 3);
            check("bp_hold_first", int'(out_first), 5);
            check("bp_hold_ready", int'(in_ready), 0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_release_valid", int'(out_valid), 0);
        check("bp_idle_ready", int'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        check("bp_second_accepted", int'(in_ready), 0);
        wait_result(0, "bp_w2", 0, 0);
        consume("bp_w2");

        // Config write during SHIFT must be ignored
        accept_word(16'hCCCC);
        write_cfg(8'h01, 4'd1);
        exp_total += 3;
        wait_result(1, "cfg_shift", 3, 5);
        consume("cfg_shift");

        // Abort mid-word: clear takes effect on the edge that would scan bit 7
        accept_word(16'hCCCC);
        for (int k = 0; k < 7; k++) begin
            tick();
        end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        exp_total = 0;
        check("abort_in_ready", int'(in_ready), 1);
        check("abort_out_valid", int'(out_valid), 0);
        check("abort_total", int'(stat_total), 0);
        saw_valid = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (out_valid) saw_valid = 1;
        end
        check("abort_no_result", saw_valid, 0);
        run_word("abort_next", 16'h6000, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
